sprite_blit: RTL and testbench
==============================

# sprite_blit

Parametrised rectangle blitter that generalises the fixed full-screen background draw. It scans a W×H region row-major from a programmable origin, generates source ROM addresses, and realigns them with ROM read latency. It drives the VGA adapter's x/y/colour/plot inputs with horizontal mirroring, a transparency key and off-screen clipping. It sits between the navigation/scene control logic and the `vga_adapter`, one instance per sprite source, with writes muxed by the scene controller.

## Interface
- `X_WIDTH`, 8: screen x coordinate width
- `Y_WIDTH`, 7: screen y coordinate width
- `SCREEN_W`, 160: visible columns; writes with x ≥ SCREEN_W are suppressed
- `SCREEN_H`, 120: visible rows; writes with y ≥ SCREEN_H are suppressed
- `ADDR_WIDTH`, 15: source ROM address width
- `COLOUR_WIDTH`, 9: pixel colour width
- `ROM_LATENCY`, 1: ROM address-to-data cycles, legal range 1..3
- `clk` in 1: system clock (CLOCK_50)
- `resetn` in 1: asynchronous active-low reset
- `start` in 1: begin blit; sampled only in IDLE
- `x_init` in X_WIDTH: origin column
- `y_init` in Y_WIDTH: origin row
- `width` in X_WIDTH: region width in pixels
- `height` in Y_WIDTH: region height in pixels
- `base_addr` in ADDR_WIDTH: ROM address of source pixel (0,0)
- `mirror` in 1: 1 = horizontally flipped source read
- `key_en` in 1: 1 = transparency keying enabled
- `key_colour` in COLOUR_WIDTH: transparent colour value
- `rom_addr` out ADDR_WIDTH: source ROM address
- `rom_data` in COLOUR_WIDTH: ROM output, valid ROM_LATENCY cycles after `rom_addr`
- `x_out` out X_WIDTH: pixel column to the VGA adapter
- `y_out` out Y_WIDTH: pixel row to the VGA adapter
- `colour` out COLOUR_WIDTH: pixel colour to the VGA adapter
- `write_en` out 1: plot strobe
- `busy` out 1: blit in progress
- `done` out 1: one-cycle completion pulse

## Operation
- States:
  - IDLE → RUN on `start` when `width`≠0 and `height`≠0.
  - IDLE → DONE on `start` when `width`=0 or `height`=0; no writes are made.
  - RUN → DRAIN after the last pixel address is issued.
  - DRAIN → DONE after ROM_LATENCY cycles.
  - DONE → IDLE unconditionally.
- On `start` in IDLE, all inputs except `rom_data` are latched. Input changes during a blit have no effect.
- `start` in RUN, DRAIN or DONE is ignored and is not queued.
- Scan order: col 0..W-1 within each row, rows 0..H-1. One pixel address is issued per cycle with no bubbles, including at row wrap.
- Source address:
  - `mirror`=0: `base_addr + row*W + col`.
  - `mirror`=1: `base_addr + row*W + (W-1-col)`.
  - Computed with a row-base accumulator (add W per row); no multiplier.
  - Addition wraps modulo 2^ADDR_WIDTH.
- Screen coordinates:
  - `x_out = x_init + col` and `y_out = y_init + row`, each computed at X_WIDTH+1 / Y_WIDTH+1 bits for the clip test, then truncated for output.
- Per-pixel x/y/valid are delayed ROM_LATENCY stages through a shift pipeline so they align with `rom_data`.
- `write_en` = delayed valid AND in-bounds AND NOT (`key_en` AND `rom_data`==`key_colour`).
- `colour` = `rom_data` passed through combinationally in the aligned cycle.
- Clipped and keyed pixels still consume their cycle; throughput is unchanged.
- `busy` = 1 in RUN, DRAIN and DONE. `done` = 1 only in DONE.

## Timing
- Reset (asynchronous, any state): state=IDLE, pipeline valid bits cleared, outputs `rom_addr`=0, `x_out`=0, `y_out`=0, `write_en`=0, `busy`=0, `done`=0. `colour` follows `rom_data` but is don't-care while `write_en`=0.
- Reset mid-blit aborts immediately. No `done` pulse is produced, and no `write_en` occurs after reset asserts.
- With `start` sampled at edge t and N = W·H:
  - `rom_addr` for pixel k is valid in cycle t+1+k.
  - `write_en`/`x_out`/`y_out` for pixel k are valid in cycle t+1+k+ROM_LATENCY.
  - `done` is high in cycle t+1+N+ROM_LATENCY.
  - `busy` rises in cycle t+1 and falls in cycle t+2+N+ROM_LATENCY.
- Zero-size blit: `done` is high in cycle t+1, `busy` is high only in cycle t+1.
- A back-to-back blit is possible with `start` high in the first IDLE cycle after DONE, i.e. one dead cycle between blits.

## Test plan
- Full-screen blit: W=160, H=120, origin (0,0), base 0, ROM_LATENCY=1.
  - Required: exactly 19200 `write_en` pulses.
  - Pixel (x,y) shows ROM word 160y+x.
  - `done` at cycle t+19202.
  - `busy` high for 19202 cycles.
- Mirror and row wrap: W=4, H=3, origin (10,20), base 100, mirror=1.
  - Required addresses: 103,102,101,100,107,106,105,104,111,110,109,108, contiguous with no gaps.
  - Writes at x 10..13, y 20..22.
- Clipping: W=8, H=4, origin (156,118).
  - Required: only the 4×2 in-screen pixels are written, i.e. 8 pulses.
  - `done` timing is identical to the unclipped case (cycle t+34 at latency 1).
- Transparency: key_en=1, key_colour=9'h1FF, ROM pattern alternating 9'h1FF/9'h000 over a 6×1 region.
  - Required: 3 writes, all with colour 0.
  - Repeat with key_en=0: 6 writes.
- Boundary and handshake:
  - width=0 → `done` in cycle t+1 with no writes.
  - `start` pulsed during RUN → ignored; total write count unchanged.
  - ROM_LATENCY=3 variant → first write in cycle t+4.
- Reset mid-blit: assert resetn=0 after 50 pixels of a 16×16 blit.
  - Required: all outputs 0 asynchronously and no `done`.
  - A new blit after deassertion runs cleanly from pixel 0.

Source files
------------

// File: rtl/sprite_blit.sv
// sprite_blit: rectangle blitter that scans a W x H source region row-major,
// issues one ROM address per cycle, realigns pixel coordinates with the ROM
// read latency and drives the VGA adapter with mirroring, keying and clipping.
//
// rom_data is sampled with no handshake: it is valid exactly ROM_LATENCY
// cycles after the matching rom_addr. The pixel strobe write_en is a
// single-cycle qualifier with no back-pressure.
module sprite_blit #(
    parameter int X_WIDTH      = 8,
    parameter int Y_WIDTH      = 7,
    parameter int SCREEN_W     = 160,
    parameter int SCREEN_H     = 120,
    parameter int ADDR_WIDTH   = 15,
    parameter int COLOUR_WIDTH = 9,
    parameter int ROM_LATENCY  = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic [X_WIDTH-1:0]      x_init,
    input  logic [Y_WIDTH-1:0]      y_init,
    input  logic [X_WIDTH-1:0]      width,
    input  logic [Y_WIDTH-1:0]      height,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic                    mirror,
    input  logic                    key_en,
    input  logic [COLOUR_WIDTH-1:0] key_colour,
    output logic [ADDR_WIDTH-1:0]   rom_addr,
    input  logic [COLOUR_WIDTH-1:0] rom_data,
    output logic [X_WIDTH-1:0]      x_out,
    output logic [Y_WIDTH-1:0]      y_out,
    output logic [COLOUR_WIDTH-1:0] colour,
    output logic                    write_en,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int AZ = ADDR_WIDTH - X_WIDTH;
    localparam logic [X_WIDTH-1:0]    X_ONE    = 1;
    localparam logic [Y_WIDTH-1:0]    Y_ONE    = 1;
    localparam logic [ADDR_WIDTH-1:0] A_ONE    = 1;
    localparam logic [X_WIDTH:0]      SW_LIM   = (X_WIDTH+1)'(SCREEN_W);
    localparam logic [Y_WIDTH:0]      SH_LIM   = (Y_WIDTH+1)'(SCREEN_H);
    localparam logic [1:0]            LAT_LAST = 2'(ROM_LATENCY - 1);

    state_t r_state;
    state_t w_next;

    // Blit parameters captured at start
    logic [X_WIDTH-1:0]      r_x0;
    logic [Y_WIDTH-1:0]      r_y0;
    logic [X_WIDTH-1:0]      r_w;
    logic [Y_WIDTH-1:0]      r_h;
    logic                    r_mirror;
    logic                    r_key_en;
    logic [COLOUR_WIDTH-1:0] r_key;

    // Scan position of the pixel whose address is currently on rom_addr
    logic [X_WIDTH-1:0]      r_col;
    logic [Y_WIDTH-1:0]      r_row;
    logic [ADDR_WIDTH-1:0]   r_row_base;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [1:0]              r_drain;

    // Alignment pipeline; stage ROM_LATENCY lines up with rom_data
    logic [ROM_LATENCY:1]    r_v;
    logic [X_WIDTH:0]        r_xp [1:ROM_LATENCY];
    logic [Y_WIDTH:0]        r_yp [1:ROM_LATENCY];

    logic                    w_row_end;
    logic                    w_last;
    logic                    w_v0;
    logic [X_WIDTH:0]        w_x0;
    logic [Y_WIDTH:0]        w_y0;
    logic [ADDR_WIDTH-1:0]   w_w_ext;
    logic [ADDR_WIDTH-1:0]   w_in_w_ext;
    logic [ADDR_WIDTH-1:0]   w_next_row_base;
    logic                    w_in_bounds;
    logic                    w_keyed;

    assign w_row_end       = (r_col == r_w - X_ONE);
    assign w_last          = w_row_end && (r_row == r_h - Y_ONE);
    assign w_w_ext         = {{AZ{1'b0}}, r_w};
    assign w_in_w_ext      = {{AZ{1'b0}}, width};
    assign w_next_row_base = r_row_base + w_w_ext;
    assign w_x0            = {1'b0, r_x0} + {1'b0, r_col};
    assign w_y0            = {1'b0, r_y0} + {1'b0, r_row};

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (width != '0 && height != '0) ? S_RUN : S_DONE;
            S_RUN:   if (w_last) w_next = S_DRAIN;
            S_DRAIN: if (r_drain == LAT_LAST) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        w_v0      = (r_state == S_RUN);
        dbg_state = r_state;
    end

    // Parameter capture, scan counters and address generation
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x0       <= '0;
            r_y0       <= '0;
            r_w        <= '0;
            r_h        <= '0;
            r_mirror   <= 1'b0;
            r_key_en   <= 1'b0;
            r_key      <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
            r_addr     <= '0;
            r_drain    <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_x0       <= x_init;
                r_y0       <= y_init;
                r_w        <= width;
                r_h        <= height;
                r_mirror   <= mirror;
                r_key_en   <= key_en;
                r_key      <= key_colour;
                r_col      <= '0;
                r_row      <= '0;
                r_row_base <= base_addr;
                r_addr     <= mirror ? base_addr + w_in_w_ext - A_ONE : base_addr;
            end else if (r_state == S_RUN && !w_last) begin
                if (w_row_end) begin
                    // Row wrap is folded into the same cycle: no bubble
                    r_col      <= '0;
                    r_row      <= r_row + Y_ONE;
                    r_row_base <= w_next_row_base;
                    r_addr     <= r_mirror ? w_next_row_base + w_w_ext - A_ONE
                                           : w_next_row_base;
                end else begin
                    r_col  <= r_col + X_ONE;
                    r_addr <= r_mirror ? r_addr - A_ONE : r_addr + A_ONE;
                end
            end
            r_drain <= (r_state == S_DRAIN) ? r_drain + 2'd1 : 2'd0;
        end
    end

    // Delay per-pixel valid and coordinates to meet rom_data
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_v <= '0;
            for (int i = 1; i <= ROM_LATENCY; i++) begin
                r_xp[i] <= '0;
                r_yp[i] <= '0;
            end
        end else begin
            r_v[1]  <= w_v0;
            r_xp[1] <= w_x0;
            r_yp[1] <= w_y0;
            for (int i = 2; i <= ROM_LATENCY; i++) begin
                r_v[i]  <= r_v[i-1];
                r_xp[i] <= r_xp[i-1];
                r_yp[i] <= r_yp[i-1];
            end
        end
    end

    assign w_in_bounds = (r_xp[ROM_LATENCY] < SW_LIM) && (r_yp[ROM_LATENCY] < SH_LIM);
    assign w_keyed     = r_key_en && (rom_data == r_key);

    assign rom_addr = r_addr;
    assign x_out    = r_xp[ROM_LATENCY][X_WIDTH-1:0];
    assign y_out    = r_yp[ROM_LATENCY][Y_WIDTH-1:0];
    assign colour   = rom_data;
    assign write_en = r_v[ROM_LATENCY] && w_in_bounds && !w_keyed;

endmodule

// File: tb/tb_sprite_blit.sv
// Bench for sprite_blit: two instances (ROM latency 1 and 3) share stimulus;
// a per-pixel reference model predicts addresses, writes and completion timing.
module tb_sprite_blit;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [7:0]  x_init;
    logic [6:0]  y_init;
    logic [7:0]  width;
    logic [6:0]  height;
    logic [14:0] base_addr;
    logic        mirror;
    logic        key_en;
    logic [8:0]  key_colour;

    logic [14:0] rom_addr1, rom_addr3;
    logic [8:0]  rom_data1, rom_data3;
    logic [7:0]  x_out1, x_out3;
    logic [6:0]  y_out1, y_out3;
    logic [8:0]  colour1, colour3;
    logic        write_en1, write_en3;
    logic        busy1, busy3;
    logic        done1, done3;
    logic [1:0]  dbg_state1, dbg_state3;

    int n_checks = 0;
    int n_fail   = 0;
    int rom_mode = 0;
    int nwr1;

    logic [39:0] exp_q1[$];
    logic [39:0] exp_q3[$];
    logic [14:0] addr_q[$];
    logic [8:0]  rp3 [3];

    sprite_blit #(.ROM_LATENCY(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .start(start), .x_init(x_init), .y_init(y_init),
        .width(width), .height(height), .base_addr(base_addr), .mirror(mirror),
        .key_en(key_en), .key_colour(key_colour), .rom_addr(rom_addr1),
        .rom_data(rom_data1), .x_out(x_out1), .y_out(y_out1), .colour(colour1),
        .write_en(write_en1), .busy(busy1), .done(done1), .dbg_state(dbg_state1)
    );

    sprite_blit #(.ROM_LATENCY(3)) u_dut3 (
        .clk(clk), .resetn(resetn), .start(start), .x_init(x_init), .y_init(y_init),
        .width(width), .height(height), .base_addr(base_addr), .mirror(mirror),
        .key_en(key_en), .key_colour(key_colour), .rom_addr(rom_addr3),
        .rom_data(rom_data3), .x_out(x_out3), .y_out(y_out3), .colour(colour3),
        .write_en(write_en3), .busy(busy3), .done(done3), .dbg_state(dbg_state3)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Source ROM contents as a function of address
    function automatic logic [8:0] rom_f(input logic [14:0] a, input int md);
        int v;
        if (md == 1) return a[0] ? 9'h000 : 9'h1FF;
        v = int'(a) * 37 + 5;
        return v[8:0];
    endfunction

    // ROM models with latency 1 and 3
    always @(posedge clk) begin
        rom_data1 <= rom_f(rom_addr1, rom_mode);
        rp3[0]    <= rom_f(rom_addr3, rom_mode);
        rp3[1]    <= rp3[0];
        rp3[2]    <= rp3[1];
    end
    assign rom_data3 = rp3[2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Run one blit from a negedge; predicts every address, write and timing
    task automatic run_blit(input int w, input int h, input int x0, input int y0,
                            input int base, input int mir, input int ken,
                            input int key, input int md, input int pulse_mid);
        int n, d1, d3, b1, b3, nwr3;
        logic [39:0] e;
        logic [15:0] c16;
        exp_q1.delete();
        exp_q3.delete();
        addr_q.delete();
        n = w * h;
        for (int r = 0; r < h; r++) begin
            for (int cc = 0; cc < w; cc++) begin
                int k, sc, a, x, y;
                logic [8:0] d;
                logic [14:0] a15;
                k   = r * w + cc;
                sc  = (mir != 0) ? (w - 1 - cc) : cc;
                a   = (base + r * w + sc) % 32768;
                a15 = a[14:0];
                addr_q.push_back(a15);
                x = x0 + cc;
                y = y0 + r;
                d = rom_f(a15, md);
                if (x < 160 && y < 120 && !(ken != 0 && d == key[8:0])) begin
                    exp_q1.push_back({16'(k + 2), 8'(x), 7'(y), d});
                    exp_q3.push_back({16'(k + 4), 8'(x), 7'(y), d});
                end
            end
        end
        rom_mode   = md;
        x_init     = 8'(x0);
        y_init     = 7'(y0);
        width      = 8'(w);
        height     = 7'(h);
        base_addr  = 15'(base);
        mirror     = (mir != 0);
        key_en     = (ken != 0);
        key_colour = 9'(key);
        start      = 1'b1;
        d1 = 0; d3 = 0; b1 = 0; b3 = 0; nwr1 = 0; nwr3 = 0;
        @(posedge clk);
        for (int c = 1; c <= n + 5; c++) begin
            @(negedge clk);
            c16 = 16'(c);
            if (c <= n) begin
                chk("addr1", rom_addr1, addr_q[c-1]);
                chk("addr3", rom_addr3, addr_q[c-1]);
            end
            if (write_en1) begin
                nwr1++;
                if (exp_q1.size() == 0) chk("wr1_extra", 1, 0);
                else begin
                    e = exp_q1.pop_front();
                    chk("wr1", {c16, x_out1, y_out1, colour1}, e);
                end
            end
            if (write_en3) begin
                nwr3++;
                if (exp_q3.size() == 0) chk("wr3_extra", 1, 0);
                else begin
                    e = exp_q3.pop_front();
                    chk("wr3", {c16, x_out3, y_out3, colour3}, e);
                end
            end
            if (done1 && d1 == 0) d1 = c;
            if (done3 && d3 == 0) d3 = c;
            if (busy1) b1++;
            if (busy3) b3++;
            // drive after sampling
            if (c == 1) start = 1'b0;
            if (c == 2) begin
                x_init     = 8'($urandom);
                y_init     = 7'($urandom);
                width      = 8'($urandom);
                height     = 7'($urandom);
                base_addr  = 15'($urandom);
                mirror     = 1'($urandom);
                key_en     = 1'($urandom);
                key_colour = 9'($urandom);
            end
            if (pulse_mid != 0 && c == 3) start = 1'b1;
            if (c == 4) start = 1'b0;
        end
        chk("wr1_left", exp_q1.size(), 0);
        chk("wr3_left", exp_q3.size(), 0);
        chk("done1_cyc", d1, (n == 0) ? 1 : n + 2);
        chk("done3_cyc", d3, (n == 0) ? 1 : n + 4);
        chk("busy1_len", b1, (n == 0) ? 1 : n + 2);
        chk("busy3_len", b3, (n == 0) ? 1 : n + 4);
        chk("busy1_end", busy1, 0);
        chk("busy3_end", busy3, 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_addr1"}, rom_addr1, 0);
        chk({tag, "_addr3"}, rom_addr3, 0);
        chk({tag, "_x1"}, x_out1, 0);
        chk({tag, "_y1"}, y_out1, 0);
        chk({tag, "_x3"}, x_out3, 0);
        chk({tag, "_y3"}, y_out3, 0);
        chk({tag, "_we"}, {write_en1, write_en3}, 0);
        chk({tag, "_busy"}, {busy1, busy3}, 0);
        chk({tag, "_done"}, {done1, done3}, 0);
    endtask

    // Main sequence
    initial begin
        resetn = 1'b0; start = 1'b0; x_init = '0; y_init = '0; width = '0;
        height = '0; base_addr = '0; mirror = 1'b0; key_en = 1'b0; key_colour = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        resetn = 1'b1;
        @(negedge clk);

        // mirror and row wrap
        run_blit(4, 3, 10, 20, 100, 1, 0, 0, 0, 0);
        chk("mirror_nwr", nwr1, 12);
        // clipping at bottom-right corner
        run_blit(8, 4, 156, 118, 500, 0, 0, 0, 0, 0);
        chk("clip_nwr", nwr1, 8);
        // transparency on and off
        run_blit(6, 1, 30, 40, 200, 0, 1, 'h1FF, 1, 0);
        chk("key_nwr", nwr1, 3);
        run_blit(6, 1, 30, 40, 200, 0, 0, 'h1FF, 1, 0);
        chk("nokey_nwr", nwr1, 6);
        // zero-size blits
        run_blit(0, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("w0_nwr", nwr1, 0);
        run_blit(7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("h0_nwr", nwr1, 0);
        // start pulsed while running
        run_blit(10, 6, 20, 30, 1000, 0, 0, 0, 0, 1);
        chk("midstart_nwr", nwr1, 60);
        // address wrap past the top of the ROM
        run_blit(9, 3, 5, 5, 32760, 1, 0, 0, 0, 0);
        // randomized blits
        for (int i = 0; i < 10; i++) begin
            run_blit($urandom_range(0, 20), $urandom_range(0, 12), $urandom_range(0, 255),
                     $urandom_range(0, 127), $urandom_range(0, 32767), $urandom_range(0, 1),
                     $urandom_range(0, 1), $urandom_range(0, 1) ? 'h1FF : 'h000,
                     $urandom_range(0, 1), 0);
        end

        // reset mid-blit of a 16x16 region
        rom_mode = 0; x_init = 8'd3; y_init = 7'd4; width = 8'd16; height = 7'd16;
        base_addr = 15'd77; mirror = 1'b0; key_en = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 51; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        #2 resetn = 1'b0;
        #1 chk_outputs_zero("abort");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort_hold", {write_en1, write_en3, done1, done3, busy1, busy3}, 0);
        end
        resetn = 1'b1;
        @(negedge clk);
        chk("abort_idle", {write_en1, write_en3, done1, done3, busy1, busy3}, 0);
        run_blit(16, 16, 3, 4, 77, 0, 0, 0, 0, 0);
        chk("after_abort_nwr", nwr1, 256);

        // full-screen background
        run_blit(160, 120, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("full_nwr", nwr1, 19200);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
